// File: rtl/core_pkg.sv
// Shared definitions for the register-file writeback path.
package core_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  // x0 is hard-wired to zero and is never written or marked busy.
  localparam int REG_ZERO = 0;

  // Which source owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LNG
  } wb_src_t;

endpackage

// File: rtl/wb_arbiter.sv
// Write-port arbiter: the ALU wins by default, but after STARVE_LIM
// consecutive denied long-unit cycles the ALU is held for one cycle.
module wb_arbiter
  import core_pkg::*;
#(
  parameter int STARVE_LIM = 3
) (
  input  logic    clk,
  input  logic    srst,
  input  logic    alu_we,
  input  logic    lng_valid,
  output wb_src_t grant,
  output logic    alu_hold,
  output logic    lng_ready
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  logic [CNT_W-1:0] starve_reg;
  logic [CNT_W-1:0] starve_next;
  logic             hold_alu;

  // Grant selection; nothing is granted while reset is asserted.
  always_comb begin
    hold_alu = !srst && lng_valid && (starve_reg == LIM);
    grant    = WB_NONE;
    if (!srst) begin
      if (alu_we && !hold_alu) begin
        grant = WB_ALU;
      end else if (lng_valid) begin
        grant = WB_LNG;
      end
    end
    alu_hold  = hold_alu && alu_we;
    lng_ready = (grant == WB_LNG);
  end

  // Starve counter: counts denied long requests, saturating at the limit.
  always_comb begin
    starve_next = starve_reg;
    if (!lng_valid || grant == WB_LNG) begin
      starve_next = '0;
    end else if (starve_reg != LIM) begin
      starve_next = starve_reg + 1'b1;
    end
  end

  // Starve counter register.
  always_ff @(posedge clk) begin
    if (srst) begin
      starve_reg <= '0;
    end else begin
      starve_reg <= starve_next;
    end
  end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Register-file write-port controller with a busy scoreboard for
// outstanding long-latency destinations and issue hazard stalling.
module regfile_wb_scoreboard #(
  parameter int ADDR_W     = core_pkg::ADDR_W,
  parameter int DATA_W     = core_pkg::DATA_W,
  parameter int MAX_PEND   = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic                          iss_valid,
  input  logic [ADDR_W-1:0]             iss_rs1,
  input  logic [ADDR_W-1:0]             iss_rs2,
  input  logic [ADDR_W-1:0]             iss_rd,
  input  logic                          iss_long,
  output logic                          iss_stall,
  input  logic                          alu_we,
  input  logic [ADDR_W-1:0]             alu_rd,
  input  logic [DATA_W-1:0]             alu_wd,
  output logic                          alu_hold,
  input  logic                          lng_valid,
  input  logic [ADDR_W-1:0]             lng_rd,
  input  logic [DATA_W-1:0]             lng_wd,
  output logic                          lng_ready,
  output logic                          WE,
  output logic [ADDR_W-1:0]             A3,
  output logic [DATA_W-1:0]             WD,
  output logic [$clog2(MAX_PEND+1)-1:0] pend_cnt
);

  import core_pkg::*;

  localparam int NREG = 1 << ADDR_W;
  localparam int PC_W = $clog2(MAX_PEND + 1);
  localparam logic [PC_W-1:0]   PEND_MAX = PC_W'(MAX_PEND);
  localparam logic [ADDR_W-1:0] RZ       = ADDR_W'(REG_ZERO);

  wb_src_t         grant;
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic            pend_inc;
  logic            pend_dec;

  wb_arbiter #(
    .STARVE_LIM(STARVE_LIM)
  ) u_arb (
    .clk      (CLK),
    .srst     (Reset),
    .alu_we   (alu_we),
    .lng_valid(lng_valid),
    .grant    (grant),
    .alu_hold (alu_hold),
    .lng_ready(lng_ready)
  );

  // Hazard check against registered busy bits only; a bit cleared this
  // cycle releases the stall on the following cycle.
  always_comb begin
    iss_stall = Reset ||
                (iss_valid && (busy_reg[iss_rs1] || busy_reg[iss_rs2] ||
                               busy_reg[iss_rd]  ||
                               (iss_long && pend_cnt == PEND_MAX)));
  end

  assign pend_inc = iss_valid && !iss_stall && iss_long;
  assign pend_dec = (grant == WB_LNG);

  // Per-register set/clear strobes. The WAW check keeps set and clear of
  // one index from coinciding.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_mask
      assign set_mask[gi] = pend_inc && (iss_rd == ADDR_W'(gi));
      assign clr_mask[gi] = pend_dec && (lng_rd == ADDR_W'(gi));
    end
  endgenerate

  // Next busy vector; x0 can never be busy.
  always_comb begin
    busy_next    = (busy_reg & ~clr_mask) | set_mask;
    busy_next[0] = 1'b0;
  end

  // Scoreboard and pending-count state.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      busy_reg <= '0;
      pend_cnt <= '0;
    end else begin
      busy_reg <= busy_next;
      if (pend_inc && !pend_dec) begin
        pend_cnt <= pend_cnt + 1'b1;
      end else if (pend_dec && !pend_inc) begin
        pend_cnt <= pend_cnt - 1'b1;
      end
    end
  end

  // Registered write port; a grant to x0 completes but never asserts WE.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      WE <= 1'b0;
      A3 <= '0;
      WD <= '0;
    end else begin
      case (grant)
        WB_ALU: begin
          WE <= (alu_rd != RZ);
          A3 <= alu_rd;
          WD <= alu_wd;
        end
        WB_LNG: begin
          WE <= (lng_rd != RZ);
          A3 <= lng_rd;
          WD <= lng_wd;
        end
        default: WE <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Bench for regfile_wb_scoreboard: vector table plus hand sequences, with
// expected write-port results queued at drive time and checked after the edge.
module tb_regfile_wb_scoreboard;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int MP = 4;
  localparam int SL = 3;
  localparam int PW = $clog2(MP + 1);

  logic          CLK = 1'b0;
  logic          Reset = 1'b1;
  logic          iss_valid = 1'b0;
  logic [AW-1:0] iss_rs1 = '0;
  logic [AW-1:0] iss_rs2 = '0;
  logic [AW-1:0] iss_rd = '0;
  logic          iss_long = 1'b0;
  logic          iss_stall;
  logic          alu_we = 1'b0;
  logic [AW-1:0] alu_rd = '0;
  logic [DW-1:0] alu_wd = '0;
  logic          alu_hold;
  logic          lng_valid = 1'b0;
  logic [AW-1:0] lng_rd = '0;
  logic [DW-1:0] lng_wd = '0;
  logic          lng_ready;
  logic          WE;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD;
  logic [PW-1:0] pend_cnt;

  always #5 CLK = ~CLK;

  regfile_wb_scoreboard #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_PEND(MP), .STARVE_LIM(SL)
  ) dut (
    .CLK(CLK), .Reset(Reset),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rd(iss_rd), .iss_long(iss_long), .iss_stall(iss_stall),
    .alu_we(alu_we), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_hold(alu_hold),
    .lng_valid(lng_valid), .lng_rd(lng_rd), .lng_wd(lng_wd),
    .lng_ready(lng_ready),
    .WE(WE), .A3(A3), .WD(WD), .pend_cnt(pend_cnt)
  );

  typedef struct {
    logic          rst, iv;
    logic [AW-1:0] rs1, rs2, rd;
    logic          il, aw;
    logic [AW-1:0] ard;
    logic [DW-1:0] awd;
    logic          lv;
    logic [AW-1:0] lrd;
    logic [DW-1:0] lwd;
    logic          e_stall, e_hold, e_ready, e_we;
    logic [AW-1:0] e_a3;
    logic [DW-1:0] e_wd;
    int            e_pend;
    string         name;
  } vec_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd;
    int            pend;
    string         name;
  } wr_t;

  vec_t          tbl[$];
  wr_t           wq[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [31:0]   m_busy = '0;
  int            m_pend = 0;

  function automatic vec_t mk(
    logic rst, logic iv, logic [AW-1:0] rs1, logic [AW-1:0] rs2,
    logic [AW-1:0] rd, logic il, logic aw, logic [AW-1:0] ard,
    logic [DW-1:0] awd, logic lv, logic [AW-1:0] lrd, logic [DW-1:0] lwd,
    logic e_stall, logic e_hold, logic e_ready, logic e_we,
    logic [AW-1:0] e_a3, logic [DW-1:0] e_wd, int e_pend, string name);
    vec_t v;
    v.rst = rst; v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.il = il;
    v.aw = aw; v.ard = ard; v.awd = awd;
    v.lv = lv; v.lrd = lrd; v.lwd = lwd;
    v.e_stall = e_stall; v.e_hold = e_hold; v.e_ready = e_ready;
    v.e_we = e_we; v.e_a3 = e_a3; v.e_wd = e_wd; v.e_pend = e_pend;
    v.name = name;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle, check combinational outputs, then check the
  // registered write port and pending count after the edge.
  task automatic apply(vec_t v);
    wr_t w;
    wr_t got;
    Reset = v.rst; iss_valid = v.iv; iss_rs1 = v.rs1; iss_rs2 = v.rs2;
    iss_rd = v.rd; iss_long = v.il;
    alu_we = v.aw; alu_rd = v.ard; alu_wd = v.awd;
    lng_valid = v.lv; lng_rd = v.lrd; lng_wd = v.lwd;
    #1;
    chk({v.name, " iss_stall"}, 32'(iss_stall), 32'(v.e_stall));
    chk({v.name, " alu_hold"},  32'(alu_hold),  32'(v.e_hold));
    chk({v.name, " lng_ready"}, 32'(lng_ready), 32'(v.e_ready));
    if (!v.rst && v.lv && (m_pend == 0 || (v.lrd != 0 && !m_busy[v.lrd]))) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s protocol: lng_valid rd=%0d pend=%0d busy=%0b",
               v.name, v.lrd, m_pend, m_busy[v.lrd]);
    end
    w.we = v.e_we; w.a3 = v.e_a3; w.wd = v.e_wd; w.pend = v.e_pend;
    w.name = v.name;
    wq.push_back(w);
    @(posedge CLK);
    #1;
    if (v.rst) begin
      m_busy = '0;
      m_pend = 0;
    end else begin
      if (v.lv && v.e_ready) begin
        if (v.lrd != 0) m_busy[v.lrd] = 1'b0;
        m_pend--;
      end
      if (v.iv && v.il && !v.e_stall) begin
        if (v.rd != 0) m_busy[v.rd] = 1'b1;
        m_pend++;
      end
    end
    if (wq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s queue: got empty expected entry", v.name);
    end else begin
      got = wq.pop_front();
      chk({got.name, " WE"}, 32'(WE), 32'(got.we));
      if (got.we) begin
        chk({got.name, " A3"}, 32'(A3), 32'(got.a3));
        chk({got.name, " WD"}, WD, got.wd);
      end
      chk({got.name, " pend_cnt"}, 32'(pend_cnt), 32'(got.pend));
    end
    $display("txn %-18s stall=%0b hold=%0b ready=%0b WE=%0b A3=%0d WD=%08h pend=%0d",
             v.name, v.e_stall, v.e_hold, v.e_ready, WE, A3, WD, pend_cnt);
  endtask

  initial begin
    // rst iv rs1 rs2 rd il | aw ard awd | lv lrd lwd | stall hold ready | we a3 wd pend
    tbl.push_back(mk(1,1,1,2,3,1, 1,7,'h11, 1,5,'h0, 1,0,0, 0,0,'h0, 0, "reset"));
    tbl.push_back(mk(0,1,1,2,3,0, 0,0,'h0, 0,0,'h0, 0,0,0, 0,0,'h0, 0, "idle_issue"));
    tbl.push_back(mk(0,1,0,0,5,1, 0,0,'h0, 0,0,'h0, 0,0,0, 0,0,'h0, 1, "issue_long_r5"));
    tbl.push_back(mk(0,1,5,0,6,0, 0,0,'h0, 0,0,'h0, 1,0,0, 0,0,'h0, 1, "raw_r5_stall"));
    tbl.push_back(mk(0,1,5,0,6,0, 0,0,'h0, 1,5,'hDEADBEEF, 1,0,1, 1,5,'hDEADBEEF, 0, "lng_wb_r5"));
    tbl.push_back(mk(0,1,5,0,6,0, 0,0,'h0, 0,0,'h0, 0,0,0, 0,0,'h0, 0, "raw_r5_clear"));
    tbl.push_back(mk(0,0,0,0,0,0, 1,9,'hCAFE0009, 0,0,'h0, 0,0,0, 1,9,'hCAFE0009, 0, "alu_wb_r9"));
    tbl.push_back(mk(0,1,0,0,10,1, 0,0,'h0, 0,0,'h0, 0,0,0, 0,0,'h0, 1, "issue_long_r10"));
    tbl.push_back(mk(0,1,0,0,10,0, 1,11,'hA1, 1,10,'hBBBB, 1,0,0, 1,11,'hA1, 1, "starve1_waw"));
    tbl.push_back(mk(0,0,0,0,0,0, 1,11,'hA2, 1,10,'hBBBB, 0,0,0, 1,11,'hA2, 1, "starve2"));
    tbl.push_back(mk(0,0,0,0,0,0, 1,11,'hA3, 1,10,'hBBBB, 0,0,0, 1,11,'hA3, 1, "starve3"));
    tbl.push_back(mk(0,0,0,0,0,0, 1,11,'hA4, 1,10,'hBBBB, 0,1,1, 1,10,'hBBBB, 0, "starve_hold"));
    tbl.push_back(mk(0,0,0,0,0,0, 1,11,'hA4, 0,0,'h0, 0,0,0, 1,11,'hA4, 0, "alu_after_hold"));
    tbl.push_back(mk(0,0,0,0,0,0, 1,0,'h1234, 0,0,'h0, 0,0,0, 0,0,'h0, 0, "alu_wb_r0"));
    tbl.push_back(mk(0,1,0,0,0,1, 0,0,'h0, 0,0,'h0, 0,0,0, 0,0,'h0, 1, "issue_long_r0"));
    tbl.push_back(mk(0,1,0,0,0,0, 0,0,'h0, 1,0,'h5555, 0,0,1, 0,0,'h0, 0, "lng_wb_r0"));

    foreach (tbl[i]) apply(tbl[i]);

    // Fill the pending limit, then show one writeback frees a slot.
    for (int k = 1; k <= MP; k++) begin
      apply(mk(0,1,0,0,AW'(k),1, 0,0,'h0, 0,0,'h0, 0,0,0, 0,0,'h0, k, "fill_pend"));
    end
    apply(mk(0,1,0,0,20,1, 0,0,'h0, 0,0,'h0, 1,0,0, 0,0,'h0, 4, "pend_full_stall"));
    apply(mk(0,1,0,0,20,1, 0,0,'h0, 1,1,'h100, 1,0,1, 1,1,'h100, 3, "pend_drain_one"));
    apply(mk(0,1,0,0,20,1, 0,0,'h0, 0,0,'h0, 0,0,0, 0,0,'h0, 4, "pend_refill"));

    // Reset while operations are pending discards them.
    apply(mk(1,1,2,3,4,1, 1,8,'h88, 1,2,'h22, 1,0,0, 0,0,'h0, 0, "reset_mid"));
    apply(mk(0,1,2,3,4,1, 0,0,'h0, 0,0,'h0, 0,0,0, 0,0,'h0, 1, "post_reset_issue"));
    apply(mk(0,1,0,0,7,1, 0,0,'h0, 1,4,'h44, 0,0,1, 1,4,'h44, 1, "inc_dec_same"));
    apply(mk(0,1,7,0,8,0, 0,0,'h0, 0,0,'h0, 1,0,0, 0,0,'h0, 1, "raw_r7_stall"));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
